// File: rtl/pio_pin_bank.sv
// pio_pin_bank: parametrised PIO pin bank.
// Per-pin output and direction registers are written through wrapping
// (base, count) windows by OUT, PINDIRS, SET and side-set operations.
// Pad inputs pass through a two-flop synchroniser before the IN window.
// Optional feature macro: PIO_PINS_GLITCH_FILTER_EN adds a per-pin
// glitch filter of FILTER_LEN consecutive samples after the synchroniser.
module pio_pin_bank #(
  parameter int NPINS      = 32,
  parameter int BW         = $clog2(NPINS),
  parameter int CW         = $clog2(NPINS) + 1,
  parameter int FILTER_LEN = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BW-1:0]    cfg_in_base,
  input  logic [CW-1:0]    cfg_in_count,
  input  logic [BW-1:0]    cfg_out_base,
  input  logic [CW-1:0]    cfg_out_count,
  input  logic [BW-1:0]    cfg_set_base,
  input  logic [CW-1:0]    cfg_set_count,
  input  logic [BW-1:0]    cfg_ss_base,
  input  logic [CW-1:0]    cfg_ss_count,
  input  logic             cfg_ss_pindirs,
  input  logic             out_we,
  input  logic             dir_we,
  input  logic [31:0]      out_data,
  input  logic             set_we,
  input  logic             set_dir,
  input  logic [4:0]       set_data,
  input  logic             ss_we,
  input  logic [4:0]       ss_data,
  output logic [31:0]      read,
  output logic [NPINS-1:0] pad_out,
  output logic [NPINS-1:0] pad_oe,
  input  logic [NPINS-1:0] pad_in
);

  // Pin mask of a window; counts above NPINS clamp because k stops at NPINS.
  function automatic logic [NPINS-1:0] f_win_mask(input logic [BW-1:0] base,
                                                  input logic [CW-1:0] cnt);
    logic [NPINS-1:0] m;
    m = '0;
    for (int k = 0; k < NPINS; k++) begin
      if (k < int'(cnt)) m[BW'((int'(base) + k) % NPINS)] = 1'b1;
      else               m = m;
    end
    return m;
  endfunction

  // Rotate data so bit k lands on pin (base+k) mod NPINS.
  function automatic logic [NPINS-1:0] f_rotate(input logic [31:0] data,
                                                input logic [BW-1:0] base);
    logic [NPINS-1:0] r;
    r = '0;
    for (int k = 0; k < NPINS; k++) r[BW'((int'(base) + k) % NPINS)] = data[k];
    return r;
  endfunction

  // Gather the IN window from the synchronised pins, zero-extended.
  function automatic logic [31:0] f_gather(input logic [NPINS-1:0] pins,
                                           input logic [BW-1:0] base,
                                           input logic [CW-1:0] cnt);
    logic [31:0] g;
    g = '0;
    for (int k = 0; k < NPINS; k++) begin
      if (k < int'(cnt)) g[k] = pins[BW'((int'(base) + k) % NPINS)];
      else               g[k] = 1'b0;
    end
    return g;
  endfunction

  logic             r_rst_meta;
  logic             r_rst_sync;
  logic             w_rst_n;
  logic [NPINS-1:0] r_out;
  logic [NPINS-1:0] r_oe;
  logic [NPINS-1:0] w_out_nxt;
  logic [NPINS-1:0] w_oe_nxt;
  logic [NPINS-1:0] r_sync1;
  logic [NPINS-1:0] r_sync2;
  logic [NPINS-1:0] w_sync_in;
  logic [NPINS-1:0] w_out_mask, w_set_mask, w_ss_mask;
  logic [NPINS-1:0] w_out_rot, w_set_rot, w_ss_rot;

  assign w_out_mask = f_win_mask(cfg_out_base, cfg_out_count);
  assign w_set_mask = f_win_mask(cfg_set_base, cfg_set_count);
  assign w_ss_mask  = f_win_mask(cfg_ss_base, cfg_ss_count);
  assign w_out_rot  = f_rotate(out_data, cfg_out_base);
  assign w_set_rot  = f_rotate({27'd0, set_data}, cfg_set_base);
  assign w_ss_rot   = f_rotate({27'd0, ss_data}, cfg_ss_base);

  // Reset bridge: asserts immediately, releases on the clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end
  assign w_rst_n = r_rst_sync;

  // Next pin state; later assignments win: SET, then OUT, then side-set.
  always_comb begin
    w_out_nxt = r_out;
    w_oe_nxt  = r_oe;
    if (set_we && !set_dir) w_out_nxt = (w_out_nxt & ~w_set_mask) | (w_set_rot & w_set_mask);
    else                    w_out_nxt = w_out_nxt;
    if (set_we && set_dir)  w_oe_nxt = (w_oe_nxt & ~w_set_mask) | (w_set_rot & w_set_mask);
    else                    w_oe_nxt = w_oe_nxt;
    if (out_we)             w_out_nxt = (w_out_nxt & ~w_out_mask) | (w_out_rot & w_out_mask);
    else                    w_out_nxt = w_out_nxt;
    if (dir_we)             w_oe_nxt = (w_oe_nxt & ~w_out_mask) | (w_out_rot & w_out_mask);
    else                    w_oe_nxt = w_oe_nxt;
    if (ss_we && !cfg_ss_pindirs) w_out_nxt = (w_out_nxt & ~w_ss_mask) | (w_ss_rot & w_ss_mask);
    else                          w_out_nxt = w_out_nxt;
    if (ss_we && cfg_ss_pindirs)  w_oe_nxt = (w_oe_nxt & ~w_ss_mask) | (w_ss_rot & w_ss_mask);
    else                          w_oe_nxt = w_oe_nxt;
  end

  // Output and direction registers.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out <= '0;
      r_oe  <= '0;
    end else begin
      r_out <= w_out_nxt;
      r_oe  <= w_oe_nxt;
    end
  end

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_PINS_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0]   r_filt_cnt [NPINS];
  logic [NPINS-1:0] r_filt;

  // Glitch filter: accept a new level after FILTER_LEN matching samples.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_filt <= '0;
      for (int i = 0; i < NPINS; i++) r_filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NPINS; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_filt_cnt[i] <= '0;
        end else if (r_filt_cnt[i] == FCW'(FILTER_LEN - 1)) begin
          r_filt[i]     <= r_sync2[i];
          r_filt_cnt[i] <= '0;
        end else begin
          r_filt_cnt[i] <= r_filt_cnt[i] + FCW'(1);
        end
      end
    end
  end
  assign w_sync_in = r_filt;
`else
  assign w_sync_in = r_sync2;
`endif

  assign pad_out = r_out;
  assign pad_oe  = r_oe;
  assign read    = f_gather(w_sync_in, cfg_in_base, cfg_in_count);

endmodule

// File: tb/tb_pio_pin_bank.sv
// Self-checking bench for pio_pin_bank (NPINS=32): directed scenarios plus
// randomized traffic against a per-pin reference model.
module tb_pio_pin_bank;
  localparam int NP = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  cfg_in_base = '0, cfg_out_base = '0, cfg_set_base = '0, cfg_ss_base = '0;
  logic [5:0]  cfg_in_count = '0, cfg_out_count = '0, cfg_set_count = '0, cfg_ss_count = '0;
  logic        cfg_ss_pindirs = 1'b0;
  logic        out_we = 1'b0, dir_we = 1'b0, set_we = 1'b0, set_dir = 1'b0, ss_we = 1'b0;
  logic [31:0] out_data = '0;
  logic [4:0]  set_data = '0, ss_data = '0;
  logic [31:0] read;
  logic [31:0] pad_out, pad_oe;
  logic [31:0] pad_in = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_out = '0;
  logic [31:0] m_oe = '0;
  logic [31:0] hist[$];

  pio_pin_bank #(.NPINS(NP)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_in_base(cfg_in_base), .cfg_in_count(cfg_in_count),
    .cfg_out_base(cfg_out_base), .cfg_out_count(cfg_out_count),
    .cfg_set_base(cfg_set_base), .cfg_set_count(cfg_set_count),
    .cfg_ss_base(cfg_ss_base), .cfg_ss_count(cfg_ss_count),
    .cfg_ss_pindirs(cfg_ss_pindirs),
    .out_we(out_we), .dir_we(dir_we), .out_data(out_data),
    .set_we(set_we), .set_dir(set_dir), .set_data(set_data),
    .ss_we(ss_we), .ss_data(ss_data),
    .read(read), .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in)
  );

  always #5 clock = ~clock;

  // Position of pin p inside window (base, cnt), or -1 if outside.
  function automatic int win_idx(int base, int cnt, int p);
    int c, k;
    c = (cnt > NP) ? NP : cnt;
    k = (p - base + NP) % NP;
    return (k < c) ? k : -1;
  endfunction

  function automatic logic [31:0] exp_sync();
    return (hist.size() >= 2) ? hist[hist.size()-2] : 32'd0;
  endfunction

  function automatic logic [31:0] exp_read();
    logic [31:0] s, r;
    s = exp_sync();
    r = '0;
    for (int p = 0; p < NP; p++) begin
      int k;
      k = win_idx(int'(cfg_in_base), int'(cfg_in_count), p);
      if (k >= 0) r[k] = s[p];
    end
    return r;
  endfunction

  // One clock edge; the model consumes the inputs present at the edge.
  task automatic step();
    logic [31:0] n_out, n_oe, ssd, setd;
    int ks, ko, kt;
    ssd  = {27'd0, ss_data};
    setd = {27'd0, set_data};
    n_out = m_out;
    n_oe  = m_oe;
    for (int p = 0; p < NP; p++) begin
      ks = win_idx(int'(cfg_ss_base), int'(cfg_ss_count), p);
      ko = win_idx(int'(cfg_out_base), int'(cfg_out_count), p);
      kt = win_idx(int'(cfg_set_base), int'(cfg_set_count), p);
      if (ss_we && !cfg_ss_pindirs && ks >= 0) n_out[p] = ssd[ks];
      else if (out_we && ko >= 0)              n_out[p] = out_data[ko];
      else if (set_we && !set_dir && kt >= 0)  n_out[p] = setd[kt];
      if (ss_we && cfg_ss_pindirs && ks >= 0)  n_oe[p] = ssd[ks];
      else if (dir_we && ko >= 0)              n_oe[p] = out_data[ko];
      else if (set_we && set_dir && kt >= 0)   n_oe[p] = setd[kt];
    end
    @(posedge clock);
    if (!reset_n) begin
      m_out = '0;
      m_oe  = '0;
      hist.delete();
    end else begin
      m_out = n_out;
      m_oe  = n_oe;
      hist.push_back(pad_in);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic clear_strobes();
    out_we = 1'b0; dir_we = 1'b0; set_we = 1'b0; ss_we = 1'b0;
  endtask

  task automatic release_reset();
    clear_strobes();
    pad_in = '0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    hist.delete();
  endtask

  task automatic test_reset();
    cfg_in_count = 6'd32;
    pad_in = '0;
    step();
    n_checks++;
    if (pad_out !== 32'd0 || pad_oe !== 32'd0 || read !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_initial: out=%h oe=%h read=%h required all 0", pad_out, pad_oe, read);
    end
    release_reset();
  endtask

  task automatic test_reset_mid();
    cfg_out_base = 5'd0; cfg_out_count = 6'd32; out_data = 32'hA5A5_5A5A;
    out_we = 1'b1; dir_we = 1'b1;
    pad_in = 32'hFFFF_FFFF; cfg_in_base = 5'd0; cfg_in_count = 6'd32;
    step(); step(); step();
    n_checks++;
    if (pad_out !== 32'hA5A5_5A5A || read !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_mid_pre: out=%h read=%h required A5A55A5A FFFFFFFF", pad_out, read);
    end
    out_data = 32'hFFFF_FFFF;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pad_out !== 32'd0 || pad_oe !== 32'd0 || read !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async: out=%h oe=%h read=%h required all 0", pad_out, pad_oe, read);
    end
    step();
    n_checks++;
    if (pad_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_discard: out=%h required 0", pad_out);
    end
    release_reset();
    n_checks++;
    if (pad_out !== 32'd0 || pad_oe !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: out=%h oe=%h required 0", pad_out, pad_oe);
    end
  endtask

  task automatic test_wrap();
    cfg_out_base = 5'd0; cfg_out_count = 6'd32; out_data = 32'h0000_5550;
    out_we = 1'b1; dir_we = 1'b1;
    step();
    cfg_out_base = 5'd30; cfg_out_count = 6'd4; out_data = 32'h0000_000F;
    step();
    clear_strobes();
    n_checks++;
    if (pad_out !== 32'hC000_5553 || pad_oe !== 32'hC000_5553) begin
      n_fail++;
      $display("FAIL wrap: out=%h oe=%h required C0005553", pad_out, pad_oe);
    end
  endtask

  task automatic test_priority();
    cfg_out_base = 5'd0; cfg_out_count = 6'd8; out_data = 32'h0;
    cfg_ss_base = 5'd2; cfg_ss_count = 6'd2; ss_data = 5'b00011; cfg_ss_pindirs = 1'b0;
    cfg_set_base = 5'd0; cfg_set_count = 6'd5; set_data = 5'b10101; set_dir = 1'b0;
    out_we = 1'b1; ss_we = 1'b1; set_we = 1'b1;
    step();
    clear_strobes();
    n_checks++;
    if (pad_out[7:0] !== 8'h0C || pad_out !== m_out) begin
      n_fail++;
      $display("FAIL priority: out=%h required low byte 0C, model %h", pad_out, m_out);
    end
    // SET alone reaches pins the OUT window does not claim.
    cfg_set_base = 5'd31; cfg_set_count = 6'd3; set_data = 5'b00111; set_dir = 1'b1;
    set_we = 1'b1;
    step();
    clear_strobes();
    n_checks++;
    if (pad_oe[31] !== 1'b1 || pad_oe[1:0] !== 2'b11 || pad_oe !== m_oe) begin
      n_fail++;
      $display("FAIL set_dir_wrap: oe=%h required model %h", pad_oe, m_oe);
    end
  endtask

  task automatic test_in_window();
    pad_in = 32'h8000_0001; cfg_in_base = 5'd31; cfg_in_count = 6'd2;
    step();
    step();
    n_checks++;
    if (read !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL in_window: read=%h required 00000003", read);
    end
    cfg_in_count = 6'd0;
    #1;
    n_checks++;
    if (read !== 32'd0) begin
      n_fail++;
      $display("FAIL in_count0: read=%h required 0", read);
    end
  endtask

  task automatic test_clamp();
    cfg_out_base = 5'd5; cfg_out_count = 6'd40; out_data = 32'hFFFF_FFFF; out_we = 1'b1;
    step();
    n_checks++;
    if (pad_out !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL clamp_all: out=%h required FFFFFFFF", pad_out);
    end
    out_data = 32'h0000_00FF;
    step();
    clear_strobes();
    n_checks++;
    if (pad_out !== 32'h0000_1FE0) begin
      n_fail++;
      $display("FAIL clamp_pattern: out=%h required 00001FE0", pad_out);
    end
  endtask

  task automatic test_back_to_back();
    cfg_out_base = 5'd0; cfg_out_count = 6'd32; out_data = 32'h0; out_we = 1'b1;
    step();
    cfg_out_count = 6'd8; out_data = 32'h0000_00FF;
    step();
    cfg_out_base = 5'd4; out_data = 32'h0;
    step();
    clear_strobes();
    n_checks++;
    if (pad_out !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL back_to_back: out=%h required 0000000F", pad_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cfg_in_base = 5'($urandom_range(0, 31));  cfg_in_count = 6'($urandom_range(0, 40));
      cfg_out_base = 5'($urandom_range(0, 31)); cfg_out_count = 6'($urandom_range(0, 40));
      cfg_set_base = 5'($urandom_range(0, 31)); cfg_set_count = 6'($urandom_range(0, 6));
      cfg_ss_base = 5'($urandom_range(0, 31));  cfg_ss_count = 6'($urandom_range(0, 5));
      cfg_ss_pindirs = 1'($urandom_range(0, 1));
      out_we = 1'($urandom_range(0, 1)); dir_we = 1'($urandom_range(0, 1));
      set_we = 1'($urandom_range(0, 1)); set_dir = 1'($urandom_range(0, 1));
      ss_we = 1'($urandom_range(0, 1));
      out_data = $urandom; set_data = 5'($urandom); ss_data = 5'($urandom);
      pad_in = $urandom;
      step();
      n_checks++;
      if (pad_out !== m_out || pad_oe !== m_oe) begin
        n_fail++;
        $display("FAIL random_pins[%0d]: out=%h oe=%h required %h %h", i, pad_out, pad_oe, m_out, m_oe);
      end
`ifndef PIO_PINS_GLITCH_FILTER_EN
      n_checks++;
      if (read !== exp_read()) begin
        n_fail++;
        $display("FAIL random_read[%0d]: read=%h required %h", i, read, exp_read());
      end
`endif
    end
    clear_strobes();
  endtask

`ifdef PIO_PINS_GLITCH_FILTER_EN
  task automatic test_filter();
    cfg_in_base = 5'd0; cfg_in_count = 6'd32; pad_in = '0;
    for (int i = 0; i < 8; i++) step();
    pad_in = 32'h20;
    step(); step();
    pad_in = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (read[5] !== 1'b0) begin
        n_fail++;
        $display("FAIL filter_short[%0d]: read5=%b required 0", i, read[5]);
      end
    end
    pad_in = 32'h20;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++;
      if (read[5] !== (i == 5)) begin
        n_fail++;
        $display("FAIL filter_long[%0d]: read5=%b required %0d", i, read[5], (i == 5));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_priority();
    test_in_window();
    test_clamp();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef PIO_PINS_GLITCH_FILTER_EN
    test_filter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_pin_bank.md
# pio_pin_bank

Parametrised pin bank for the PIO state machine. It replaces the fixed 32-pin, shift-only pin block. Pin state is held in per-pin output and direction registers written by OUT, SET, side-set and PINDIRS operations. All pin ranges wrap around modulo `NPINS`, inputs are synchronised before they reach the core, and the pad interface is split into separate out/oe/in vectors for the top-level IO buffers.

## Interface
- `NPINS`, 32: number of GPIO pins, 2..32.
- `BW`, `$clog2(NPINS)`: width of base fields (derived).
- `CW`, `$clog2(NPINS)+1`: width of count fields (derived).
- `FILTER_LEN`, 3: consecutive identical samples required by the glitch filter (only used with the filter macro).

Ports:
- `clock` input 1: single clock. Clock is one clock; reset is asynchronous and active-low.
- `reset_n` input 1: asynchronous active-low reset.
- `cfg_in_base` input BW: first pin of the IN window.
- `cfg_in_count` input CW: width of the IN window.
- `cfg_out_base`, `cfg_out_count` input BW/CW: OUT and PINDIRS window.
- `cfg_set_base`, `cfg_set_count` input BW/CW: SET window.
- `cfg_ss_base`, `cfg_ss_count` input BW/CW: side-set window, count 0..5.
- `cfg_ss_pindirs` input 1: 1 means side-set drives directions instead of values.
- `out_we` input 1: write `out_data` into the OUT window's output register.
- `dir_we` input 1: write `out_data` into the OUT window's direction register.
- `out_data` input 32: OUT/PINDIRS data, LSB maps to the base pin.
- `set_we` input 1: write `set_data` to the SET window.
- `set_dir` input 1: 1 means the SET write targets directions.
- `set_data` input 5: SET payload.
- `ss_we` input 1: apply `ss_data` to the side-set window.
- `ss_data` input 5: side-set payload.
- `read` output 32: IN window data, LSB is the base pin, zero-extended.
- `pad_out` output NPINS: output register to pads.
- `pad_oe` output NPINS: direction register, 1 means drive.
- `pad_in` input NPINS: raw pad inputs, asynchronous.

## Operation
- Window mask for (base, count):
  - bit `(base+k) mod NPINS` is set for k < min(count, NPINS).
  - count 0 selects no pins.
  - count > NPINS clamps to NPINS.
- Write mapping: data bit k goes to pin `(base+k) mod NPINS`, a rotate rather than a shift, so windows wrap past pin NPINS-1 to pin 0.
- Register write rules:
  - Pins outside a window hold their value.
  - OUT and SET update `pad_out`.
  - PINDIRS and SET with `set_dir` update `pad_oe`.
  - Side-set updates `pad_out`, or `pad_oe` when `cfg_ss_pindirs` = 1.
- Simultaneous writes to the same register and pin: side-set beats OUT/SET, and OUT beats SET. Writes to different registers never conflict.
- Input path: two-flop synchroniser per pin, producing `sync_in`.
- Read path:
  - `read` bit k = `sync_in[(cfg_in_base+k) mod NPINS]` for k < clamped count, else 0.
  - The read path is combinational from the synchroniser, so config changes affect `read` in the same cycle.
- There is no bus-level state machine. Per-pin state is held in the output, direction, synchroniser and filter registers.

## Timing
- Reset values: `pad_out` = 0, `pad_oe` = 0 (all pins are inputs), synchroniser and filter flops = 0, so `read` = 0.
- Reset is asynchronous assert and synchronous deassert at the core. A reset asserted mid-write discards that write.
- Write latency: a strobe at edge N is visible on `pad_out`/`pad_oe` after edge N, i.e. in cycle N+1.
- Input latency without the filter: a `pad_in` change is visible on `read` after 2 clock edges.
- Back-to-back writes on consecutive cycles each take effect. The last write wins per pin.

## Configuration
- `PIO_PINS_GLITCH_FILTER_EN`
  - Defined: after the synchroniser, each pin has a saturating counter. `sync_in` updates only after the new level is sampled `FILTER_LEN` consecutive cycles, and a mismatch restarts the counter. Input latency becomes 2+`FILTER_LEN` edges. Pulses shorter than `FILTER_LEN` cycles never reach `read`.
  - Undefined: the synchroniser output drives `read` directly, with no counters synthesised.

## Test plan
- Reset: assert `reset_n`=0 mid-run. Required: `pad_out`=0, `pad_oe`=0 and `read`=0 immediately, without waiting for a clock edge.
- Wrap-around OUT, with NPINS=32: base 30, count 4, `out_data`=0xF, `out_we` and `dir_we` both high. Required next cycle: pins 30, 31, 0, 1 high and driven; all other pins hold their prior value.
- Priority: same cycle, OUT base 0 count 8 data 0x00, side-set base 2 count 2 data 0b11. Required: `pad_out`[7:0] = 0x0C.
- IN window: `pad_in`=0x8000_0001, base 31, count 2. Required: `read`=0x3 two edges later; with count 0, `read`=0.
- Clamp: `cfg_out_count`=40 with NPINS=32 and `out_data`=0xFFFF_FFFF. Required: all 32 pins set, with no extra wrap beyond NPINS.
- Filter, with the macro defined and FILTER_LEN=3: a 2-cycle high pulse on `pad_in[5]` leaves `read[5]`=0. A 3-cycle high makes `read[5]`=1 exactly 5 edges after the rise.
